// File: rtl/sram_req_arbiter.sv
// rtl/sram_req_arbiter.sv - two-master SRAM-like request arbiter with in-order return routing; SRAM_ARB_RR_EN selects round-robin
module sram_req_arbiter #(
    parameter int MAX_OUTST = 4,
    parameter int PTR_W     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [1:0]  m0_size,
    input  logic [31:0] m0_addr,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_wdata,
    output logic        m0_addr_ok,
    output logic        m0_data_ok,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [1:0]  m1_size,
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_wdata,
    output logic        m1_addr_ok,
    output logic        m1_data_ok,
    output logic [31:0] m1_rdata,
    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [31:0] s_addr,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_wdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    input  logic [31:0] s_rdata
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(MAX_OUTST);

    state_t              state;
    state_t              state_nx;
    logic                owner;
    logic                owner_nx;
    logic                winner;
    logic                push;
    logic                pop;
    logic                room;
    logic                head;
    logic [MAX_OUTST-1:0] fifo_q;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W:0]      count;

    // A response is only meaningful if some accepted request is waiting for it.
    assign pop  = s_data_ok && (count != '0);
    assign push = (state == LOCKED) && s_addr_ok;
    // A pop this cycle frees a slot, so a full FIFO can still grant.
    assign room = (count != FULL_CNT) || pop;
    assign head = fifo_q[rd_ptr];

`ifdef SRAM_ARB_RR_EN
    logic rr_last;

    // Remember who was pushed last so a contended grant alternates.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last <= 1'b0;
        end else if (push) begin
            rr_last <= owner;
        end
    end

    // On contention the master not granted last time wins.
    always_comb begin
        winner = m1_req;
        if (m0_req && m1_req) begin
            winner = ~rr_last;
        end
    end
`else
    // Fixed priority: the data port (m1) beats instruction fetch (m0).
    always_comb begin
        winner = m1_req;
    end
`endif

    // State and owner register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            owner <= 1'b0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
        end
    end

    // Grant in IDLE when there is room; release the lock once the slave accepts.
    always_comb begin
        state_nx = state;
        owner_nx = owner;
        case (state)
            IDLE: begin
                if ((m0_req || m1_req) && room) begin
                    state_nx = LOCKED;
                    owner_nx = winner;
                end
            end
            LOCKED: begin
                if (s_addr_ok) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Return-order FIFO of owners: one bit per accepted transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_q <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr] <= owner;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // The owner holds its request stable while locked, so the slave side is a plain mux.
    assign s_req   = !reset && (state == LOCKED);
    assign s_wr    = owner ? m1_wr    : m0_wr;
    assign s_size  = owner ? m1_size  : m0_size;
    assign s_addr  = owner ? m1_addr  : m0_addr;
    assign s_wstrb = owner ? m1_wstrb : m0_wstrb;
    assign s_wdata = owner ? m1_wdata : m0_wdata;

    assign m0_addr_ok = s_req && s_addr_ok && !owner;
    assign m1_addr_ok = s_req && s_addr_ok && owner;

    assign m0_data_ok = !reset && pop && !head;
    assign m1_data_ok = !reset && pop && head;
    assign m0_rdata   = s_rdata;
    assign m1_rdata   = s_rdata;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb/tb_sram_req_arbiter.sv - self-checking bench for sram_req_arbiter (SRAM_ARB_RR_EN aware)
module tb_sram_req_arbiter;

    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [1:0]  m0_size, m1_size;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_wr;
    logic [1:0]  s_size;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_addr_ok, s_data_ok;
    logic [31:0] s_rdata;

    always #5 clk = ~clk;

    sram_req_arbiter #(.MAX_OUTST(MAXO), .PTR_W(2)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_addr(m0_addr),
        .m0_wstrb(m0_wstrb), .m0_wdata(m0_wdata),
        .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_addr(m1_addr),
        .m1_wstrb(m1_wstrb), .m1_wdata(m1_wdata),
        .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr),
        .s_wstrb(s_wstrb), .s_wdata(s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: who holds the slave port, and a queue of owners awaiting responses.
    bit md_locked, md_owner, md_last;
    bit md_q[$];
    bit nx_clear, nx_pop, nx_push, nx_grant, nx_winner;
    bit exp_ack0, exp_ack1, exp_dok0, exp_dok1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Compare DUT against the model for the current (stable) inputs and plan the next model state.
    task automatic model_check();
        bit any_req;
        int after_pop;
        exp_ack0  = !reset && md_locked && s_addr_ok && !md_owner;
        exp_ack1  = !reset && md_locked && s_addr_ok && md_owner;
        nx_pop    = !reset && s_data_ok && (md_q.size() > 0);
        exp_dok0  = nx_pop && (md_q[0] == 1'b0);
        exp_dok1  = nx_pop && (md_q[0] == 1'b1);
        chk("s_req", s_req, !reset && md_locked);
        chk("addr_ok", {m1_addr_ok, m0_addr_ok}, {exp_ack1, exp_ack0});
        chk("data_ok", {m1_data_ok, m0_data_ok}, {exp_dok1, exp_dok0});
        chk("rdata", {m1_rdata, m0_rdata}, {s_rdata, s_rdata});
        if (!reset && md_locked) begin
            chk("s_ctrl", {s_wr, s_size, s_wstrb},
                md_owner ? {m1_wr, m1_size, m1_wstrb} : {m0_wr, m0_size, m0_wstrb});
            chk("s_addr", s_addr, md_owner ? m1_addr : m0_addr);
            chk("s_wdata", s_wdata, md_owner ? m1_wdata : m0_wdata);
        end
        any_req   = m0_req || m1_req;
        after_pop = md_q.size() - (nx_pop ? 1 : 0);
`ifdef SRAM_ARB_RR_EN
        nx_winner = (m0_req && m1_req) ? !md_last : m1_req;
`else
        nx_winner = m1_req;
`endif
        nx_clear = reset;
        nx_push  = !reset && md_locked && s_addr_ok;
        nx_grant = !reset && !md_locked && any_req && (after_pop < MAXO);
    endtask

    task automatic commit();
        bit tmp;
        if (nx_clear) begin
            md_q.delete();
            md_locked = 1'b0;
            md_owner  = 1'b0;
            md_last   = 1'b0;
        end else begin
            if (nx_pop) tmp = md_q.pop_front();
            if (nx_push) begin
                md_q.push_back(md_owner);
                md_last   = md_owner;
                md_locked = 1'b0;
            end else if (nx_grant) begin
                md_locked = 1'b1;
                md_owner  = nx_winner;
            end
        end
    endtask

    task automatic half();
        @(negedge clk);
        model_check();
    endtask

    task automatic fin();
        @(posedge clk);
        commit();
        cyc++;
        #1;
    endtask

    task automatic tick();
        half();
        fin();
    endtask

    task automatic clear_in();
        m0_req = 0; m0_wr = 0; m0_size = 2'd2; m0_addr = '0; m0_wstrb = '0; m0_wdata = '0;
        m1_req = 0; m1_wr = 0; m1_size = 2'd2; m1_addr = '0; m1_wstrb = '0; m1_wdata = '0;
        s_addr_ok = 0; s_data_ok = 0; s_rdata = 32'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_in();
        half();
        chk("rst_outputs", {s_req, m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok}, 5'b0);
        fin();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        md_locked = 0; md_owner = 0; md_last = 0;
        exp_ack0 = 0; exp_ack1 = 0;
        reset = 1'b1;
        clear_in();

        // 1: lone m0 read, accepted in the second cycle, data routed back to m0.
        do_reset();
        m0_req = 1; m0_addr = 32'h1c000000;
        half(); chk("t1_arb_sreq", s_req, 0); fin();
        s_addr_ok = 1;
        half();
        chk("t1_m0_addr_ok", m0_addr_ok, 1);
        chk("t1_s_addr", s_addr, 32'h1c000000);
        fin();
        m0_req = 0; s_addr_ok = 0; s_data_ok = 1; s_rdata = 32'hDEADBEEF;
        half();
        chk("t1_m0_data_ok", m0_data_ok, 1);
        chk("t1_m0_rdata", m0_rdata, 32'hDEADBEEF);
        chk("t1_m1_data_ok", m1_data_ok, 0);
        fin();
        s_data_ok = 0;

        // 2: simultaneous requests, m1 first then m0; responses in the same order.
        do_reset();
        m0_req = 1; m0_addr = 32'h100; m1_req = 1; m1_addr = 32'h200;
        tick();
        s_addr_ok = 1;
        half(); chk("t2_first_m1", {m1_addr_ok, m0_addr_ok}, 2'b10); chk("t2_s_addr_m1", s_addr, 32'h200); fin();
        m1_req = 0; s_addr_ok = 0;
        half(); chk("t2_gap_sreq", s_req, 0); fin();
        s_addr_ok = 1;
        half(); chk("t2_second_m0", {m1_addr_ok, m0_addr_ok}, 2'b01); fin();
        m0_req = 0; s_addr_ok = 0; s_data_ok = 1; s_rdata = 32'h11111111;
        half(); chk("t2_resp1", {m1_data_ok, m0_data_ok}, 2'b10); fin();
        s_rdata = 32'h22222222;
        half(); chk("t2_resp2", {m1_data_ok, m0_data_ok}, 2'b01); fin();
        s_data_ok = 0;

        // 3: both request continuously for 4 grants.
        do_reset();
        m0_req = 1; m1_req = 1;
        for (int g = 0; g < 4; g++) begin
            s_addr_ok = 0;
            tick();
            s_addr_ok = 1;
            half();
`ifdef SRAM_ARB_RR_EN
            chk("t3_grant", {m1_addr_ok, m0_addr_ok}, (g % 2 == 0) ? 2'b10 : 2'b01);
`else
            chk("t3_grant", {m1_addr_ok, m0_addr_ok}, 2'b10);
`endif
            fin();
        end
        m0_req = 0; m1_req = 0; s_addr_ok = 0; s_data_ok = 1;
        for (int g = 0; g < 4; g++) begin
            half();
`ifdef SRAM_ARB_RR_EN
            chk("t3_resp", {m1_data_ok, m0_data_ok}, (g % 2 == 0) ? 2'b10 : 2'b01);
`else
            chk("t3_resp", {m1_data_ok, m0_data_ok}, 2'b10);
`endif
            fin();
        end
        s_data_ok = 0;

        // 4: fill the FIFO, the next request waits, one response reopens it.
        do_reset();
        m0_req = 1; m0_addr = 32'h40; s_addr_ok = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            half(); chk("t4_full_no_sreq", s_req, 0); fin();
        end
        s_data_ok = 1;
        half(); chk("t4_pop", m0_data_ok, 1); chk("t4_pop_sreq", s_req, 0); fin();
        s_data_ok = 0;
        half(); chk("t4_sreq_after_pop", s_req, 1); fin();
        m0_req = 0; s_addr_ok = 0; s_data_ok = 1;
        repeat (4) tick();
        s_data_ok = 0;

        // 5: locked m1 write, slave stalls 5 cycles; m0 waits.
        do_reset();
        m1_req = 1; m1_wr = 1; m1_size = 2'd2; m1_addr = 32'h8000; m1_wstrb = 4'b0011;
        m1_wdata = 32'hCAFEF00D;
        m0_req = 1; m0_addr = 32'h1c000000; m0_wdata = 32'h12345678; m0_wstrb = 4'hf;
        tick();
        for (int i = 0; i < 5; i++) begin
            half();
            chk("t5_sreq", s_req, 1);
            chk("t5_s_addr", s_addr, 32'h8000);
            chk("t5_s_ctrl", {s_wr, s_size, s_wstrb}, {1'b1, 2'd2, 4'b0011});
            chk("t5_s_wdata", s_wdata, 32'hCAFEF00D);
            chk("t5_m0_ignored", m0_addr_ok, 0);
            fin();
        end
        s_addr_ok = 1;
        half(); chk("t5_m1_ack", {m1_addr_ok, m0_addr_ok}, 2'b10); fin();
        m1_req = 0; s_addr_ok = 0;

        // 6: reset with two outstanding and a lock held; late response is dropped.
        tick();
        s_addr_ok = 1;
        half(); chk("t6_m0_ack", m0_addr_ok, 1); fin();
        m0_req = 0; s_addr_ok = 0; m1_req = 1; m1_wr = 0;
        tick();
        reset = 1; s_addr_ok = 1; s_data_ok = 1;
        half();
        chk("t6_rst_outputs", {s_req, m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok}, 5'b0);
        fin();
        reset = 0; m1_req = 0; s_addr_ok = 0;
        for (int i = 0; i < 2; i++) begin
            half();
            chk("t6_late_resp", {s_req, m0_data_ok, m1_data_ok}, 3'b0);
            fin();
        end
        s_data_ok = 0;

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (!(m0_req && !exp_ack0)) begin
                m0_req = ($urandom_range(0, 2) == 0);
                m0_wr = 1'($urandom); m0_size = 2'($urandom_range(0, 2));
                m0_addr = $urandom; m0_wstrb = 4'($urandom); m0_wdata = $urandom;
            end
            if (!(m1_req && !exp_ack1)) begin
                m1_req = ($urandom_range(0, 2) == 0);
                m1_wr = 1'($urandom); m1_size = 2'($urandom_range(0, 2));
                m1_addr = $urandom; m1_wstrb = 4'($urandom); m1_wdata = $urandom;
            end
            s_addr_ok = ($urandom_range(0, 1) == 1);
            s_data_ok = (md_q.size() > 0) ? ($urandom_range(0, 2) == 0)
                                          : ($urandom_range(0, 29) == 0);
            s_rdata   = $urandom;
            reset     = ($urandom_range(0, 399) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
